// File: rtl/bp_update_ctrl_pkg.sv
// Shared types for the branch-predictor update path.
// Holds the update bundle and the controller state encoding.
package rv32i_types;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
    logic        is_br;
    logic        is_jal;
  } bp_upd_t;

  typedef enum logic {
    BPC_INIT,
    BPC_RUN
  } bp_ctrl_state_t;

  function automatic logic upd_keep(
    input logic v,
    input logic br,
    input logic jal
  );
    return v & (br | jal);
  endfunction

endpackage

// File: rtl/bp_update_ctrl_fifo.sv
// bp_upd_fifo: 2-write / 1-read circular queue of bp_upd_t.
// Ports: clk, rst/clr_n (sync active-low), wr_en/wr_data x2, rd_en, count, head, empty.
module bp_upd_fifo
  import rv32i_types::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_n,
  input  logic    [1:0]     wr_en,
  input  bp_upd_t [1:0]     wr_data,
  input  logic              rd_en,
  output logic    [CW-1:0]  count,
  output bp_upd_t           head,
  output logic              empty
);

  bp_upd_t mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW-1:0] wp1;

  // Slot 1 lands behind slot 0 only if slot 0 was written.
  assign wp1 = wp + AW'(wr_en[0]);

  always_ff @(posedge clk) begin
    if (wr_en[0]) mem[wp] <= wr_data[0];
    if (wr_en[1]) mem[wp1] <= wr_data[1];
  end

  always_ff @(posedge clk) begin
    if (!rst || !clr_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      wp    <= wp1 + AW'(wr_en[1]);
      rp    <= rp + AW'(rd_en);
      count <= count + CW'(wr_en[0])
                     + CW'(wr_en[1])
                     - CW'(rd_en);
    end
  end

  assign head  = mem[rp];
  assign empty = (count == '0);

endmodule

// File: rtl/bp_update_ctrl.sv
// bp_update_ctrl: serialises committed branch/JAL updates into BTB/counter writes,
// owns committed GHR, clears tables after reset/flush. Option: BP_UPD_BYPASS_EN.
module bp_update_ctrl
  import rv32i_types::*;
#(
  parameter int IDX_BITS   = 10,
  parameter int GHR_BITS   = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          upd_valid,
  input  logic [1:0][31:0]    upd_pc,
  input  logic [1:0][31:0]    upd_target,
  input  logic [1:0]          upd_taken,
  input  logic [1:0]          upd_is_br,
  input  logic [1:0]          upd_is_jal,
  output logic                upd_ready,
  input  logic                flush_req,
  output logic                init_busy,
  output logic                tbl_we,
  output logic                tbl_clear,
  output logic [IDX_BITS-1:0] tbl_idx,
  output logic [31:0]         tbl_pc,
  output logic [31:0]         tbl_target,
  output logic                tbl_taken,
  output logic [GHR_BITS-1:0] ghr
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [IDX_BITS-1:0] LAST =
    IDX_BITS'((2 ** IDX_BITS) - 1);

  bp_ctrl_state_t state_q;
  bp_ctrl_state_t state_d;
  logic [IDX_BITS-1:0] sweep_q;
  logic [IDX_BITS-1:0] sweep_d;
  logic [GHR_BITS-1:0] ghr_q;

  bp_upd_t [1:0] slot;
  logic    [1:0] keep;
  logic    [1:0] wr_en;
  logic [CW-1:0] count;
  logic [CW-1:0] free;
  bp_upd_t       head;
  bp_upd_t       wr_ent;
  logic          empty;
  logic          run;
  logic          acc;
  logic          byp;
  logic          deq;
  logic          wr_upd;

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      slot[s].pc     = upd_pc[s];
      slot[s].target = upd_target[s];
      slot[s].taken  = upd_taken[s];
      slot[s].is_br  = upd_is_br[s];
      slot[s].is_jal = upd_is_jal[s];
      keep[s] = upd_keep(upd_valid[s],
                         upd_is_br[s],
                         upd_is_jal[s]);
    end
  end

  assign run  = rst && (state_q == BPC_RUN);
  // Free count ignores this cycle's dequeue.
  assign free = CW'(FIFO_DEPTH) - count;
  assign upd_ready = run && (free >= CW'(2));
  assign acc  = upd_ready && !flush_req;
  assign init_busy = !rst || (state_q == BPC_INIT);

`ifdef BP_UPD_BYPASS_EN
  assign byp = acc && empty && keep[0];
`else
  assign byp = 1'b0;
`endif

  assign wr_en[0] = acc && keep[0] && !byp;
  assign wr_en[1] = acc && keep[1];
  assign deq      = run && !empty && !flush_req;
  assign wr_upd   = deq || byp;
  assign wr_ent   = byp ? slot[0] : head;

  bp_upd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr_n   (!flush_req),
    .wr_en   (wr_en),
    .wr_data (slot),
    .rd_en   (deq),
    .count   (count),
    .head    (head),
    .empty   (empty)
  );

  always_comb begin
    state_d    = state_q;
    sweep_d    = sweep_q;
    tbl_we     = 1'b0;
    tbl_clear  = 1'b0;
    tbl_idx    = '0;
    tbl_pc     = '0;
    tbl_target = '0;
    tbl_taken  = 1'b0;
    unique case (1'b1)
      (state_q == BPC_INIT): begin
        tbl_we    = rst;
        tbl_clear = 1'b1;
        tbl_idx   = sweep_q;
        sweep_d   = sweep_q + IDX_BITS'(1);
        if (sweep_q == LAST) state_d = BPC_RUN;
      end
      wr_upd: begin
        tbl_we     = 1'b1;
        tbl_idx    = wr_ent.pc[IDX_BITS+1:2];
        tbl_pc     = wr_ent.pc;
        tbl_target = wr_ent.target;
        tbl_taken  = wr_ent.taken | wr_ent.is_jal;
      end
      default: ;
    endcase
    if (flush_req) begin
      state_d = BPC_INIT;
      sweep_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= BPC_INIT;
      sweep_q <= '0;
      ghr_q   <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      if (flush_req)
        ghr_q <= '0;
      else if (wr_upd && wr_ent.is_br)
        ghr_q <= {ghr_q[GHR_BITS-2:0], wr_ent.taken};
    end
  end

  assign ghr = ghr_q;

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Directed bench for bp_update_ctrl: sweep, ordering, GHR,
// JAL, back-pressure, flush and mid-sweep reset.
module tb_bp_update_ctrl;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       upd_valid;
  logic [1:0][31:0] upd_pc;
  logic [1:0][31:0] upd_target;
  logic [1:0]       upd_taken;
  logic [1:0]       upd_is_br;
  logic [1:0]       upd_is_jal;
  logic             upd_ready;
  logic             flush_req;
  logic             init_busy;
  logic             tbl_we;
  logic             tbl_clear;
  logic [9:0]       tbl_idx;
  logic [31:0]      tbl_pc;
  logic [31:0]      tbl_target;
  logic             tbl_taken;
  logic [9:0]       ghr;

  int total = 0;
  int bad   = 0;
  logic [9:0] ghr_m;

  always #5 clk = ~clk;

  bp_update_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_target (upd_target),
    .upd_taken  (upd_taken),
    .upd_is_br  (upd_is_br),
    .upd_is_jal (upd_is_jal),
    .upd_ready  (upd_ready),
    .flush_req  (flush_req),
    .init_busy  (init_busy),
    .tbl_we     (tbl_we),
    .tbl_clear  (tbl_clear),
    .tbl_idx    (tbl_idx),
    .tbl_pc     (tbl_pc),
    .tbl_target (tbl_target),
    .tbl_taken  (tbl_taken),
    .ghr        (ghr)
  );

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    upd_valid  = '0;
    upd_pc     = '0;
    upd_target = '0;
    upd_taken  = '0;
    upd_is_br  = '0;
    upd_is_jal = '0;
  endtask

  task automatic put(int s, logic [31:0] pc, logic [31:0] tg,
                     logic tk, logic br, logic jal);
    upd_valid[s]  = 1'b1;
    upd_pc[s]     = pc;
    upd_target[s] = tg;
    upd_taken[s]  = tk;
    upd_is_br[s]  = br;
    upd_is_jal[s] = jal;
  endtask

  // Checks n sweep cycles starting at the current sample point.
  task automatic sweep_chk(string tag, int n);
    int errs = 0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        @(negedge clk);
        #1;
      end
      if (!(tbl_we === 1'b1 && tbl_clear === 1'b1 &&
            tbl_idx === 10'(i) && init_busy === 1'b1 &&
            upd_ready === 1'b0))
        errs++;
    end
    chk(tag, 64'(errs), 64'd0);
  endtask

  // Finds the next update write within a few cycles, idling slots.
  task automatic wait_wr(string tag);
    logic ok = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (tbl_we === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      idle();
      #1;
    end
    chk(tag, 64'(ok), 64'd1);
  endtask

  logic [31:0] exp_pc [$];
  logic        exp_tk [$];

  initial begin
    int commits;
    int writes;
    logic stall;
    logic [31:0] p;
    logic t;

    rst = 1'b0;
    flush_req = 1'b0;
    idle();

    // Reset held
    repeat (2) @(negedge clk);
    #1;
    chk("rst_we", 64'(tbl_we), 64'd0);
    chk("rst_ready", 64'(upd_ready), 64'd0);
    chk("rst_busy", 64'(init_busy), 64'd1);

    // 1: sweep after release
    @(negedge clk);
    rst = 1'b1;
    #1;
    sweep_chk("sweep1", 1024);
    @(negedge clk);
    #1;
    chk("run_busy", 64'(init_busy), 64'd0);
    chk("run_ready", 64'(upd_ready), 64'd1);
    chk("run_we", 64'(tbl_we), 64'd0);
    chk("run_ghr", 64'(ghr), 64'd0);

    // 2: dual branch in one cycle
    @(negedge clk);
    put(0, 32'h100, 32'h180, 1'b1, 1'b1, 1'b0);
    put(1, 32'h204, 32'h300, 1'b0, 1'b1, 1'b0);
    #1;
    wait_wr("t2_wr0");
    chk("t2_idx0", 64'(tbl_idx), 64'h40);
    chk("t2_tk0", 64'(tbl_taken), 64'd1);
    chk("t2_clr0", 64'(tbl_clear), 64'd0);
    chk("t2_pc0", 64'(tbl_pc), 64'h100);
    @(negedge clk);
    idle();
    #1;
    wait_wr("t2_wr1");
    chk("t2_idx1", 64'(tbl_idx), 64'h81);
    chk("t2_tk1", 64'(tbl_taken), 64'd0);
    chk("t2_tg1", 64'(tbl_target), 64'h300);
    @(negedge clk);
    #1;
    chk("t2_idle", 64'(tbl_we), 64'd0);
    chk("t2_ghr", 64'(ghr), 64'h2);
    ghr_m = 10'h2;

    // 4: JAL does not shift GHR, forces taken
    @(negedge clk);
    put(0, 32'h300, 32'h400, 1'b0, 1'b0, 1'b1);
    #1;
    wait_wr("t4_wr");
    chk("t4_idx", 64'(tbl_idx), 64'hC0);
    chk("t4_tk", 64'(tbl_taken), 64'd1);
    chk("t4_tg", 64'(tbl_target), 64'h400);
    chk("t4_pc", 64'(tbl_pc), 64'h300);
    @(negedge clk);
    idle();
    #1;
    chk("t4_ghr", 64'(ghr), 64'(ghr_m));

    // 3: five back-to-back dual commits
    commits = 0;
    writes  = 0;
    stall   = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      idle();
      if (commits < 5) begin
        if (upd_ready) begin
          for (int s = 0; s < 2; s++) begin
            p = 32'h1000 + 32'((commits * 2 + s) * 4);
            t = ((commits * 2 + s) % 3) == 0;
            put(s, p, p + 32'h40, t, 1'b1, 1'b0);
            exp_pc.push_back(p);
            exp_tk.push_back(t);
          end
          commits++;
        end else begin
          stall = 1'b1;
        end
      end
      #1;
      if (tbl_we === 1'b1) begin
        writes++;
        if (exp_pc.size() == 0) begin
          chk("t3_extra", 64'(tbl_pc), 64'hFFFF_FFFF);
        end else begin
          p = exp_pc.pop_front();
          t = exp_tk.pop_front();
          chk("t3_pc", 64'(tbl_pc), 64'(p));
          chk("t3_tk", 64'(tbl_taken), 64'(t));
          ghr_m = {ghr_m[8:0], t};
        end
      end
      if (commits == 5 && exp_pc.size() == 0) break;
    end
    @(negedge clk);
    idle();
    #1;
    chk("t3_commits", 64'(commits), 64'd5);
    chk("t3_writes", 64'(writes), 64'd10);
    chk("t3_stall", 64'(stall), 64'd1);
    chk("t3_ghr", 64'(ghr), 64'(ghr_m));
    chk("t3_idle", 64'(tbl_we), 64'd0);

    // 5: flush with entries queued
    @(negedge clk);
    put(0, 32'h2000, 32'h0, 1'b1, 1'b1, 1'b0);
    put(1, 32'h2004, 32'h0, 1'b1, 1'b1, 1'b0);
    #1;
    @(negedge clk);
    idle();
    #1;
    chk("t5_ready", 64'(upd_ready), 64'd1);
    put(0, 32'h2008, 32'h0, 1'b1, 1'b1, 1'b0);
    put(1, 32'h200C, 32'h0, 1'b1, 1'b1, 1'b0);
    #1;
    @(negedge clk);
    idle();
    flush_req = 1'b1;
    #1;
    chk("t5_flush_we", 64'(tbl_we), 64'd0);
    @(negedge clk);
    flush_req = 1'b0;
    #1;
    chk("t5_ghr", 64'(ghr), 64'd0);
    chk("t5_idx", 64'(tbl_idx), 64'd0);
    chk("t5_clr", 64'(tbl_clear), 64'd1);
    chk("t5_busy", 64'(init_busy), 64'd1);

    // 6: reset mid-sweep at idx 500
    sweep_chk("sweep2", 500);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("t6_we", 64'(tbl_we), 64'd0);
      chk("t6_ready", 64'(upd_ready), 64'd0);
      chk("t6_busy", 64'(init_busy), 64'd1);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    sweep_chk("sweep3", 1024);
    @(negedge clk);
    #1;
    chk("t6_run", 64'(init_busy), 64'd0);
    chk("t6_rdy", 64'(upd_ready), 64'd1);
    chk("t6_ghr", 64'(ghr), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
